seq_det_sched: RTL and testbench
================================

# seq_det_sched

Job scheduler for a single shared sub-sequence detector. Two requesters each submit a detection job: run length N, repeat count M and a cycle timeout. The block arbitrates between them round-robin, loads the job's N/M onto the detector and issues a clear. It then watches the detector's pulse until a hit or a timeout, and returns one result per job over a valid/ready response channel.

## Interface
- TMO_W, 16, width of the timeout and elapsed-cycle counters
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  2  per-requester job valid; bit i belongs to requester i
- req_ready  output  2  per-requester accept; at most one bit high
- req_n  input  12  N per requester; [5:0] is requester 0, [11:6] is requester 1
- req_m  input  10  M per requester; [4:0] is requester 0, [9:5] is requester 1
- req_tmo  input  2*TMO_W  timeout in cycles per requester; 0 means no timeout
- det_n  output  6  N driven to the detector, registered
- det_m  output  5  M driven to the detector, registered
- det_clr  output  1  one-cycle synchronous clear to the detector
- det_pulse  input  1  detector hit pulse
- rsp_valid  output  1  result valid
- rsp_ready  input  1  result accept
- rsp_id  output  1  requester index that owns the result
- rsp_hit  output  1  1 = hit, 0 = timeout or error
- rsp_err  output  1  job rejected because N==0 or M==0
- rsp_cycles  output  TMO_W  RUN cycles elapsed up to and including the terminating cycle

## Operation
- State machine: IDLE, LOAD, RUN, RESP.
- IDLE
  - Arbiter pointer `ptr` (reset 0) names the preferred requester.
  - Grant goes to `ptr` if its req_valid is high, otherwise to the other requester if valid.
  - req_ready is combinational, asserted only for the granted index, and only in IDLE.
  - On valid&&ready: latch id, N, M and tmo, then go to LOAD.
  - If the latched N==0 or M==0, go to RESP instead with err=1, hit=0, cycles=0. det_clr is not pulsed in this case.
- LOAD (exactly 1 cycle)
  - det_n/det_m show the new job's N/M from this cycle.
  - det_clr=1.
  - Elapsed counter is cleared to 0.
  - Always goes to RUN.
- RUN
  - Elapsed counter increments by 1 each cycle and saturates at all-ones.
  - det_pulse=1 ends the job: hit=1, go to RESP.
  - Otherwise, if tmo!=0 and the pre-increment counter == tmo-1, the job ends with hit=0 and goes to RESP.
  - det_pulse and timeout in the same cycle: hit wins.
  - det_pulse is ignored in every state other than RUN.
- RESP
  - rsp_valid=1; rsp_* fields stay stable until rsp_valid&&rsp_ready.
  - On handshake: ptr <= ~id, then go to IDLE.
  - No new request is accepted while in RESP.
- rsp_cycles equals the post-increment counter value at termination. A hit in the first RUN cycle gives 1; a timeout with tmo=T gives T.
- det_n/det_m hold their last job values between jobs.
- The arbitration pointer advances only on a completed response, so the requester that was just served loses the next tie.

## Timing
- Reset values:
  - state IDLE, ptr 0
  - req_ready 0, det_clr 0, det_n 0, det_m 0
  - rsp_valid 0, rsp_id 0, rsp_hit 0, rsp_err 0, rsp_cycles 0
- Accept cycle A (IDLE): LOAD in A+1 with det_clr high; RUN starts at A+2.
- Minimum accept-to-rsp_valid latency:
  - hit in the first RUN cycle: 3 cycles
  - error job: 1 cycle
- rsp_ready held high: back-to-back jobs are separated by one IDLE cycle (rsp handshake, then IDLE, then accept).
- rsp_valid never drops without a handshake.
- Asynchronous reset mid-job: the job is aborted, no response is produced, and all outputs return to reset values immediately.

## Test plan
- Single job, requester 0, N=3, M=2, tmo=100, det_pulse driven at RUN cycle 5 -> rsp_id=0, hit=1, err=0, cycles=5; det_clr high exactly one cycle, in LOAD.
- Timeout, requester 1, N=4, M=1, tmo=10, no pulse -> hit=0, cycles=10; rsp_valid exactly 12 cycles after accept.
- Both requesters valid continuously, 4 jobs, rsp_ready=1 -> grant order 0, 1, 0, 1; det_n/det_m follow each job's values.
- Error job N=0 -> rsp_valid the cycle after accept with err=1, hit=0, cycles=0; det_clr never asserts.
- Pulse and timeout in the same cycle (tmo=6, pulse at RUN cycle 6) -> hit=1, cycles=6.
- rsp_ready held low for 20 cycles, with rst_n asserted during the next job's RUN -> response fields stay stable until the handshake; the reset clears all outputs asynchronously and no response follows for the aborted job.

Source files
------------

// File: rtl/seq_det_sched_if.sv
// -----------------------------------------------------------------------------
// seq_det_sched_if
// Bundles the job request bus, the detector control/pulse lines and the
// result channel of seq_det_sched.
//   req_valid/req_ready : per-requester job handshake (bit i = requester i)
//   req_n/req_m/req_tmo : per-requester N, M and timeout, packed lane by lane
//   det_n/det_m/det_clr : job parameters and clear towards the detector
//   det_pulse           : hit pulse from the detector
//   rsp_*               : one result per job, valid/ready handshake
// Modports: slave = the scheduler, master = requesters/detector/consumer.
// -----------------------------------------------------------------------------
interface seq_det_sched_if #(
    parameter int TMO_W = 16
) ();
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [11:0]        req_n;
    logic [9:0]         req_m;
    logic [2*TMO_W-1:0] req_tmo;
    logic [5:0]         det_n;
    logic [4:0]         det_m;
    logic               det_clr;
    logic               det_pulse;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic               rsp_hit;
    logic               rsp_err;
    logic [TMO_W-1:0]   rsp_cycles;

    modport slave (
        input  req_valid, req_n, req_m, req_tmo, det_pulse, rsp_ready,
        output req_ready, det_n, det_m, det_clr,
               rsp_valid, rsp_id, rsp_hit, rsp_err, rsp_cycles
    );

    modport master (
        output req_valid, req_n, req_m, req_tmo, det_pulse, rsp_ready,
        input  req_ready, det_n, det_m, det_clr,
               rsp_valid, rsp_id, rsp_hit, rsp_err, rsp_cycles
    );
endinterface

// File: rtl/seq_det_sched.sv
// -----------------------------------------------------------------------------
// seq_det_sched
// Schedules detection jobs from two requesters onto one shared sub-sequence
// detector. Round-robin arbitration, loads N/M plus a one-cycle clear, then
// watches det_pulse until a hit or a timeout and returns one result per job.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_det_sched_if.slave (requests, detector control, results)
// -----------------------------------------------------------------------------
module seq_det_sched #(
    parameter int TMO_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_det_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [TMO_W-1:0] CNT_ONE = TMO_W'(1);

    state_t           state_reg;
    logic             ptr_reg;
    logic [5:0]       det_n_reg;
    logic [4:0]       det_m_reg;
    logic             det_clr_reg;
    logic [TMO_W-1:0] tmo_reg;
    logic [TMO_W-1:0] cnt_reg;
    logic             rsp_valid_reg;
    logic             rsp_id_reg;
    logic             rsp_hit_reg;
    logic             rsp_err_reg;
    logic [TMO_W-1:0] rsp_cycles_reg;

    // Per-requester views of the packed request fields.
    logic [5:0]       lane_n   [2];
    logic [4:0]       lane_m   [2];
    logic [TMO_W-1:0] lane_tmo [2];
    logic [1:0]       grant_oh;

    logic             grant_valid;
    logic             grant_id;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_n[gi]   = bus.req_n[gi*6 +: 6];
            assign lane_m[gi]   = bus.req_m[gi*5 +: 5];
            assign lane_tmo[gi] = bus.req_tmo[gi*TMO_W +: TMO_W];
            assign grant_oh[gi] = grant_valid && (grant_id == 1'(gi));
        end
    endgenerate

    // Preferred requester first, the other one only if the preferred is idle.
    // Gated by rst_n so req_ready reads 0 while reset is held.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ptr_reg;
        if (rst_n && (state_reg == IDLE)) begin
            if (bus.req_valid[ptr_reg]) begin
                grant_valid = 1'b1;
                grant_id    = ptr_reg;
            end else if (bus.req_valid[~ptr_reg]) begin
                grant_valid = 1'b1;
                grant_id    = ~ptr_reg;
            end
        end
    end

    logic             job_bad;
    logic [TMO_W-1:0] cnt_inc;
    logic             tmo_expired;

    assign job_bad     = (lane_n[grant_id] == '0) || (lane_m[grant_id] == '0);
    // Elapsed counter saturates instead of wrapping.
    assign cnt_inc     = (&cnt_reg) ? cnt_reg : (cnt_reg + CNT_ONE);
    // Compare on the pre-increment value so the reported count equals tmo.
    assign tmo_expired = (tmo_reg != '0) && (cnt_reg == (tmo_reg - CNT_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ptr_reg        <= 1'b0;
            det_n_reg      <= '0;
            det_m_reg      <= '0;
            det_clr_reg    <= 1'b0;
            tmo_reg        <= '0;
            cnt_reg        <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_hit_reg    <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_cycles_reg <= '0;
        end else begin
            det_clr_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        rsp_id_reg <= grant_id;
                        tmo_reg    <= lane_tmo[grant_id];
                        if (job_bad) begin
                            // Rejected job: answer straight away, detector untouched.
                            state_reg      <= RESP;
                            rsp_valid_reg  <= 1'b1;
                            rsp_hit_reg    <= 1'b0;
                            rsp_err_reg    <= 1'b1;
                            rsp_cycles_reg <= '0;
                        end else begin
                            state_reg   <= LOAD;
                            det_n_reg   <= lane_n[grant_id];
                            det_m_reg   <= lane_m[grant_id];
                            det_clr_reg <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    cnt_reg   <= '0;
                    state_reg <= RUN;
                end
                RUN: begin
                    cnt_reg <= cnt_inc;
                    // A pulse takes priority over a coincident timeout.
                    if (bus.det_pulse || tmo_expired) begin
                        state_reg      <= RESP;
                        rsp_valid_reg  <= 1'b1;
                        rsp_hit_reg    <= bus.det_pulse;
                        rsp_err_reg    <= 1'b0;
                        rsp_cycles_reg <= cnt_inc;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        // The requester just served loses the next tie.
                        ptr_reg       <= ~rsp_id_reg;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = grant_oh;
    assign bus.det_n      = det_n_reg;
    assign bus.det_m      = det_m_reg;
    assign bus.det_clr    = det_clr_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_id     = rsp_id_reg;
    assign bus.rsp_hit    = rsp_hit_reg;
    assign bus.rsp_err    = rsp_err_reg;
    assign bus.rsp_cycles = rsp_cycles_reg;
endmodule

// File: tb/tb_seq_det_sched.sv
// -----------------------------------------------------------------------------
// tb_seq_det_sched
// Directed scenarios plus randomized traffic for seq_det_sched. A job-level
// timeline model (accept cycle, elapsed cycles, pending result) predicts every
// output each cycle; literal expectations pin the model on known scenarios.
// -----------------------------------------------------------------------------
module tb_seq_det_sched;
    localparam int TMO_W = 16;
    localparam int SAT   = (1 << TMO_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_det_sched_if #(.TMO_W(TMO_W)) bus ();

    seq_det_sched #(.TMO_W(TMO_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Stimulus: one pending job per requester, plus pulse and rsp_ready.
    bit       jv [2];
    bit [5:0] jn [2];
    bit [4:0] jm [2];
    int       jt [2];
    bit       pulse;
    bit       rdy;

    // Model: job timeline, not a state machine.
    int       cyc;
    bit       m_busy, m_pend, m_err_job, m_ptr, m_id;
    int       m_acc, m_tmo;
    bit       p_hit, p_err, p_id;
    int       p_cycles;
    bit [5:0] m_det_n;
    bit [4:0] m_det_m;
    bit [1:0] acc_mask;
    int       clr_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive_bus();
        bus.req_valid = {jv[1], jv[0]};
        bus.req_n     = {jn[1], jn[0]};
        bus.req_m     = {jm[1], jm[0]};
        bus.req_tmo   = {TMO_W'(jt[1]), TMO_W'(jt[0])};
        bus.det_pulse = pulse;
        bus.rsp_ready = rdy;
    endtask

    function automatic int grant_pick();
        if (m_busy)      return -1;
        if (jv[m_ptr])   return int'(m_ptr);
        if (jv[!m_ptr])  return int'(!m_ptr);
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_pend = 0; m_err_job = 0; m_ptr = 0; m_id = 0;
        m_det_n = '0; m_det_m = '0;
        p_hit = 0; p_err = 0; p_id = 0; p_cycles = 0;
    endtask

    task automatic compare();
        int       g;
        bit [1:0] exp_rdy;
        bit       exp_clr;
        g       = grant_pick();
        exp_rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        exp_clr = m_busy && !m_pend && !m_err_job && (cyc - m_acc == 1);
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("det_n",     32'(bus.det_n),     32'(m_det_n));
        check("det_m",     32'(bus.det_m),     32'(m_det_m));
        check("det_clr",   32'(bus.det_clr),   32'(exp_clr));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(m_pend));
        if (m_pend) begin
            check("rsp_id",     32'(bus.rsp_id),     32'(p_id));
            check("rsp_hit",    32'(bus.rsp_hit),    32'(p_hit));
            check("rsp_err",    32'(bus.rsp_err),    32'(p_err));
            check("rsp_cycles", 32'(bus.rsp_cycles), 32'(p_cycles));
        end
        if (bus.det_clr) clr_cnt++;
    endtask

    task automatic advance();
        int g;
        int el;
        acc_mask = 2'b00;
        g = grant_pick();
        if (m_pend) begin
            if (rdy) begin
                m_ptr  = !p_id;
                m_pend = 0;
                m_busy = 0;
            end
        end else if (m_busy && !m_err_job && (cyc - m_acc >= 2)) begin
            el = cyc - m_acc - 1;
            if (pulse || (m_tmo != 0 && el == m_tmo)) begin
                m_pend   = 1;
                p_id     = m_id;
                p_hit    = pulse;
                p_err    = 0;
                p_cycles = (el > SAT) ? SAT : el;
            end
        end else if (!m_busy && g >= 0) begin
            acc_mask[g] = 1'b1;
            m_busy      = 1;
            m_acc       = cyc;
            m_id        = g[0];
            m_tmo       = jt[g];
            m_err_job   = (jn[g] == 0) || (jm[g] == 0);
            if (m_err_job) begin
                m_pend = 1; p_id = g[0]; p_hit = 0; p_err = 1; p_cycles = 0;
            end else begin
                m_det_n = jn[g];
                m_det_m = jm[g];
            end
        end
        cyc++;
    endtask

    // One clock: entered and left at posedge+1.
    task automatic step();
        drive_bus();
        #1;
        compare();
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string nm, output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 200) begin
            step();
            lat++;
        end
        check({nm, "_rsp_seen"}, 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_req_ready"},  32'(bus.req_ready),  32'd0);
        check({nm, "_det_clr"},    32'(bus.det_clr),    32'd0);
        check({nm, "_det_n"},      32'(bus.det_n),      32'd0);
        check({nm, "_det_m"},      32'(bus.det_m),      32'd0);
        check({nm, "_rsp_valid"},  32'(bus.rsp_valid),  32'd0);
        check({nm, "_rsp_id"},     32'(bus.rsp_id),     32'd0);
        check({nm, "_rsp_hit"},    32'(bus.rsp_hit),    32'd0);
        check({nm, "_rsp_err"},    32'(bus.rsp_err),    32'd0);
        check({nm, "_rsp_cycles"}, 32'(bus.rsp_cycles), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        cyc = 0; clr_cnt = 0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            jv[i] = 1; jn[i] = 6'd1; jm[i] = 5'd1; jt[i] = 0;
        end
        pulse = 0; rdy = 0;
        drive_bus();
        #2;
        check_all_zero("reset");       // req_valid high, reset held
        jv[0] = 0; jv[1] = 0;
        drive_bus();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single hit job on requester 0, pulse at RUN cycle 5.
        jv[0] = 1; jn[0] = 6'd3; jm[0] = 5'd2; jt[0] = 100; rdy = 1; clr_cnt = 0;
        step();
        jv[0] = 0;
        check("t1_det_clr", 32'(bus.det_clr), 32'd1);
        check("t1_det_n",   32'(bus.det_n),   32'd3);
        check("t1_det_m",   32'(bus.det_m),   32'd2);
        step();
        repeat (4) step();
        pulse = 1; step(); pulse = 0;
        check("t1_rsp_valid",  32'(bus.rsp_valid),  32'd1);
        check("t1_rsp_id",     32'(bus.rsp_id),     32'd0);
        check("t1_rsp_hit",    32'(bus.rsp_hit),    32'd1);
        check("t1_rsp_err",    32'(bus.rsp_err),    32'd0);
        check("t1_rsp_cycles", 32'(bus.rsp_cycles), 32'd5);
        step(); step();
        check("t1_clr_count", 32'(clr_cnt), 32'd1);

        // Timeout on requester 1, tmo=10.
        jv[1] = 1; jn[1] = 6'd4; jm[1] = 5'd1; jt[1] = 10;
        step();
        jv[1] = 0;
        wait_rsp("t2", lat);
        check("t2_latency",    32'(lat + 1),        32'd12);
        check("t2_rsp_id",     32'(bus.rsp_id),     32'd1);
        check("t2_rsp_hit",    32'(bus.rsp_hit),    32'd0);
        check("t2_rsp_cycles", 32'(bus.rsp_cycles), 32'd10);
        step();

        // Both requesters valid, immediate hits: grants alternate.
        jv[0] = 1; jn[0] = 6'd11; jm[0] = 5'd3; jt[0] = 50;
        jv[1] = 1; jn[1] = 6'd22; jm[1] = 5'd7; jt[1] = 50;
        pulse = 1;
        for (int k = 0; k < 4; k++) begin
            wait_rsp("t3", lat);
            check("t3_latency",    32'(lat),            32'd3);
            check("t3_rsp_id",     32'(bus.rsp_id),     32'(k % 2));
            check("t3_det_n",      32'(bus.det_n),      32'(jn[k % 2]));
            check("t3_det_m",      32'(bus.det_m),      32'(jm[k % 2]));
            check("t3_rsp_cycles", 32'(bus.rsp_cycles), 32'd1);
            jn[k % 2] = jn[k % 2] + 6'd1;
            if (k == 3) begin
                jv[0] = 0; jv[1] = 0;
            end
            step();
        end
        pulse = 0;

        // Error job, N=0.
        jv[0] = 1; jn[0] = 6'd0; jm[0] = 5'd5; jt[0] = 0; clr_cnt = 0;
        step();
        jv[0] = 0;
        check("t4_rsp_valid",  32'(bus.rsp_valid),  32'd1);
        check("t4_rsp_err",    32'(bus.rsp_err),    32'd1);
        check("t4_rsp_hit",    32'(bus.rsp_hit),    32'd0);
        check("t4_rsp_cycles", 32'(bus.rsp_cycles), 32'd0);
        check("t4_det_n_hold", 32'(bus.det_n),      32'd23);
        step(); step();
        check("t4_clr_count", 32'(clr_cnt), 32'd0);

        // Pulse and timeout together at RUN cycle 6.
        jv[1] = 1; jn[1] = 6'd5; jm[1] = 5'd4; jt[1] = 6;
        step();
        jv[1] = 0;
        step();
        repeat (5) step();
        pulse = 1; step(); pulse = 0;
        check("t5_rsp_hit",    32'(bus.rsp_hit),    32'd1);
        check("t5_rsp_cycles", 32'(bus.rsp_cycles), 32'd6);
        check("t5_rsp_id",     32'(bus.rsp_id),     32'd1);
        step();

        // Back-pressure for 20 cycles, then reset during the next job's RUN.
        jv[0] = 1; jn[0] = 6'd7; jm[0] = 5'd2; jt[0] = 3; rdy = 0;
        step();
        jv[0] = 0;
        wait_rsp("t6", lat);
        jv[1] = 1; jn[1] = 6'd9; jm[1] = 5'd3; jt[1] = 0;
        for (int k = 0; k < 20; k++) begin
            check("t6_hold_valid",  32'(bus.rsp_valid),  32'd1);
            check("t6_hold_cycles", 32'(bus.rsp_cycles), 32'd3);
            check("t6_hold_hit",    32'(bus.rsp_hit),    32'd0);
            step();
        end
        rdy = 1;
        step();
        step();
        jv[1] = 0;
        step();
        repeat (3) step();
        #1 rst_n = 1'b0;
        jv[0] = 1; jv[1] = 1;
        drive_bus();
        #1;
        check_all_zero("t6_midreset");
        model_reset();
        jv[0] = 0; jv[1] = 0;
        drive_bus();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 30; k++) begin
            pulse = ($urandom_range(0, 1) == 1);
            step();
        end
        check("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
        pulse = 0;

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!jv[i] && $urandom_range(0, 3) == 0) begin
                    jv[i] = 1;
                    jn[i] = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                    jm[i] = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    jt[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 25));
                end
            end
            pulse = ($urandom_range(0, 9) == 0);
            rdy   = ($urandom_range(0, 2) != 0);
            step();
            for (int i = 0; i < 2; i++)
                if (acc_mask[i]) jv[i] = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
